uart_tx_serializer: RTL

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Purpose:
//   Serialises a whole message of MSG_LEN bytes onto a UART line. Bytes are
//   pulled from an upstream ROM whose address counter is advanced by a
//   one-cycle `increment` pulse issued each time a byte is latched. Frames
//   of one message are sent back to back with no idle gap. `done` pulses
//   once after the final stop bit of the message completes.
//
// Optional feature:
//   UART_TX_PARITY_EN - when defined, an even-parity bit (XOR of the data
//   bits) is inserted between the last data bit and the stop bit.
//
// Parameters:
//   WIDTH        - data bits per frame (>= 2)
//   CLKS_PER_BIT - clock cycles per serial bit (>= 2)
//   MSG_LEN      - bytes per message
//
// Ports:
//   clk       in   system clock, all logic on its rising edge
//   rst       in   synchronous active-high reset
//   start     in   request to transmit one full message (ignored when busy)
//   data_in   in   current byte from upstream ROM
//   increment out  registered one-cycle pulse advancing the ROM address
//   tx        out  registered serial line, idle high
//   busy      out  high while a message is in progress
//   done      out  registered one-cycle pulse at message end
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int MSG_LEN      = 84
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             increment,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    // Counter widths; guarded so degenerate parameter values still elaborate.
    localparam int TW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BCW = (WIDTH > 1)        ? $clog2(WIDTH)        : 1;
    localparam int MCW = (MSG_LEN > 1)      ? $clog2(MSG_LEN)      : 1;

    localparam logic [TW-1:0]  TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] BIT_LAST   = BCW'(WIDTH - 1);
    localparam logic [MCW-1:0] BYTE_LAST  = MCW'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_q,    state_d;
    logic [TW-1:0]    timer_q,    timer_d;
    logic [BCW-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [MCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [WIDTH-1:0] shift_q,    shift_d;
    logic             tx_q,       tx_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             inc_q,      inc_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q,   parity_d;
`endif

    logic bit_end;

    // -----------------------------------------------------------------------
    // Next-state and output logic.
    // tx is registered, so every transition loads tx_d with the level the
    // line must carry in the state being entered. The shift register is
    // consumed LSB first: each time a bit is put on the line the register
    // shifts right so shift_q[0] always holds the next data bit.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        inc_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        bit_end = (timer_q == TIMER_LAST);

        // Bit timer free-runs in every active state and restarts on each
        // bit boundary; IDLE holds it at zero.
        if (state_q != IDLE) begin
            timer_d = bit_end ? '0 : timer_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d    = 1'b1;
                timer_d = '0;
                if (start) begin
                    state_d  = START;
                    shift_d  = data_in;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^data_in;
`endif
                    inc_d    = 1'b1;
                    busy_d   = 1'b1;
                    tx_d     = 1'b0;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif

            STOP: begin
                if (bit_end) begin
                    if (byte_cnt_q == BYTE_LAST) begin
                        // Message complete: back to idle, one done pulse.
                        state_d    = IDLE;
                        byte_cnt_d = '0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        tx_d       = 1'b1;
                    end else begin
                        // Chain straight into the next frame with no idle
                        // gap; the ROM already presents the next byte.
                        state_d    = START;
                        byte_cnt_d = byte_cnt_q + MCW'(1);
                        shift_d    = data_in;
`ifdef UART_TX_PARITY_EN
                        parity_d   = ^data_in;
`endif
                        inc_d      = 1'b1;
                        tx_d       = 1'b0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                timer_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers. Reset aborts any frame in progress at this edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            inc_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            inc_q      <= inc_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign increment = inc_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
